// File: rtl/leitor_banco_registradores.sv
// Read-side sequencer that dumps the register bank as a byte stream over valid/ready.
// Optional trailing XOR checksum byte is enabled with `define LEITOR_CHECKSUM_EN.
module leitor_banco_registradores #(
    parameter int NUM_REGS     = 4,
    parameter int LARGURA_END  = 2,
    parameter int LARGURA_DADO = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iniciar,
    output logic [LARGURA_END-1:0]  endereco_leitura,
    input  logic [LARGURA_DADO-1:0] dado_leitura,
    output logic [LARGURA_DADO-1:0] saida_dado,
    output logic                    saida_valida,
    input  logic                    saida_pronta,
    output logic                    saida_ultimo,
    output logic                    ocupado,
    output logic                    concluido
);

`ifdef LEITOR_CHECKSUM_EN
    typedef enum logic [2:0] {OCIOSO, LER, ENVIA, CHECKSUM, FIM} estado_t;
`else
    typedef enum logic [1:0] {OCIOSO, LER, ENVIA, FIM} estado_t;
`endif

    localparam logic [LARGURA_END-1:0] ULTIMO = LARGURA_END'(NUM_REGS - 1);

    estado_t                 estado_q, estado_d;
    logic [LARGURA_END-1:0]  indice_q, indice_d;
    logic [LARGURA_DADO-1:0] dado_q, dado_d;
    logic                    handshake;
`ifdef LEITOR_CHECKSUM_EN
    logic [LARGURA_DADO-1:0] acc_q, acc_d;
`endif

    assign handshake = saida_valida & saida_pronta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            indice_q <= '0;
            dado_q   <= '0;
`ifdef LEITOR_CHECKSUM_EN
            acc_q    <= '0;
`endif
        end else begin
            estado_q <= estado_d;
            indice_q <= indice_d;
            dado_q   <= dado_d;
`ifdef LEITOR_CHECKSUM_EN
            acc_q    <= acc_d;
`endif
        end
    end

    always_comb begin
        estado_d = estado_q;
        indice_d = indice_q;
        dado_d   = dado_q;
`ifdef LEITOR_CHECKSUM_EN
        acc_d    = acc_q;
`endif
        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    indice_d = '0;
                    estado_d = LER;
`ifdef LEITOR_CHECKSUM_EN
                    acc_d    = '0;
`endif
                end
            end
            LER: begin
                dado_d   = dado_leitura;
                estado_d = ENVIA;
            end
            ENVIA: begin
                if (handshake) begin
`ifdef LEITOR_CHECKSUM_EN
                    acc_d = acc_q ^ dado_q;
`endif
                    if (indice_q == ULTIMO) begin
`ifdef LEITOR_CHECKSUM_EN
                        // The checksum byte reuses the output register, so it stays stable until accepted.
                        dado_d   = acc_q ^ dado_q;
                        estado_d = CHECKSUM;
`else
                        estado_d = FIM;
`endif
                    end else begin
                        indice_d = indice_q + 1'b1;
                        estado_d = LER;
                    end
                end
            end
`ifdef LEITOR_CHECKSUM_EN
            CHECKSUM: begin
                if (handshake) begin
                    estado_d = FIM;
                end
            end
`endif
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_comb begin
        endereco_leitura = '0;
        saida_valida     = 1'b0;
        saida_ultimo     = 1'b0;
        ocupado          = 1'b0;
        concluido        = 1'b0;
        case (estado_q)
            LER: begin
                endereco_leitura = indice_q;
                ocupado          = 1'b1;
            end
            ENVIA: begin
                endereco_leitura = indice_q;
                saida_valida     = 1'b1;
                ocupado          = 1'b1;
`ifndef LEITOR_CHECKSUM_EN
                saida_ultimo     = (indice_q == ULTIMO);
`endif
            end
`ifdef LEITOR_CHECKSUM_EN
            CHECKSUM: begin
                endereco_leitura = indice_q;
                saida_valida     = 1'b1;
                saida_ultimo     = 1'b1;
                ocupado          = 1'b1;
            end
`endif
            FIM: begin
                endereco_leitura = indice_q;
                ocupado          = 1'b1;
                concluido        = 1'b1;
            end
            default: begin
                endereco_leitura = '0;
            end
        endcase
    end

    assign saida_dado = dado_q;

endmodule

// File: tb/tb_leitor_banco_registradores.sv
// Directed bench for leitor_banco_registradores with a behavioural register bank.
// Expected dump length follows LEITOR_CHECKSUM_EN.
module tb_leitor_banco_registradores;

`ifdef LEITOR_CHECKSUM_EN
    localparam int N_BYTES = 5;
`else
    localparam int N_BYTES = 4;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [1:0] endereco_leitura;
    logic [7:0] dado_leitura;
    logic [7:0] saida_dado;
    logic       saida_valida;
    logic       saida_pronta;
    logic       saida_ultimo;
    logic       ocupado;
    logic       concluido;

    logic [7:0] banco [4];
    assign dado_leitura = banco[endereco_leitura];

    leitor_banco_registradores #(
        .NUM_REGS    (4),
        .LARGURA_END (2),
        .LARGURA_DADO(8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .iniciar         (iniciar),
        .endereco_leitura(endereco_leitura),
        .dado_leitura    (dado_leitura),
        .saida_dado      (saida_dado),
        .saida_valida    (saida_valida),
        .saida_pronta    (saida_pronta),
        .saida_ultimo    (saida_ultimo),
        .ocupado         (ocupado),
        .concluido       (concluido)
    );

    always #5 clk = ~clk;

    int vetores = 0;
    int erros   = 0;

    logic [7:0] bytes_q [$];
    bit         ultimo_q [$];
    int         ciclos_q [$];
    int         n_concluido;
    int         ciclo_conc;
    int         ocupado_falhas;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vetores++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
        end
    endtask

    task automatic carrega_banco(input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            banco[i] = v[31-8*i -: 8];
        end
    endtask

    // Runs one dump with optional stall, bank writes and a spurious iniciar pulse.
    task automatic roda_dump(input int idx_parada, input int ciclos_parada, input logic [7:0] dado_parada,
                             input int idx_esc_a, input int reg_a, input logic [7:0] val_a,
                             input int idx_esc_b, input int reg_b, input logic [7:0] val_b,
                             input int ciclo_reiniciar);
        int  ciclo;
        int  parados;
        int  aceitos;
        bit  aceitou;
        bit  esc_a;
        bit  esc_b;
        bit  fim_visto;
        bytes_q.delete();
        ultimo_q.delete();
        ciclos_q.delete();
        n_concluido    = 0;
        ciclo_conc     = -1;
        ocupado_falhas = 0;
        parados        = 0;
        esc_a          = 0;
        esc_b          = 0;
        fim_visto      = 0;
        saida_pronta   = 1'b1;
        iniciar        = 1'b1;
        @(negedge clk);
        ciclo = 1;
        while (ciclo < 300 && !fim_visto) begin
            iniciar      = (ciclo == ciclo_reiniciar);
            saida_pronta = 1'b1;
            aceitou      = 0;
            aceitos      = bytes_q.size();
            if (!ocupado) ocupado_falhas++;
            if (concluido) begin
                n_concluido++;
                ciclo_conc = ciclo;
                fim_visto  = 1;
                confere("valida_em_fim", saida_valida, 1'b0);
            end
            if (saida_valida) begin
                if (aceitos == idx_esc_a && !esc_a) begin
                    banco[reg_a] = val_a;
                    esc_a        = 1;
                end
                if (aceitos == idx_parada && parados < ciclos_parada) begin
                    saida_pronta = 1'b0;
                    parados++;
                    confere("parada_dado", saida_dado, dado_parada);
                    confere("parada_end", endereco_leitura, idx_parada);
                end else begin
                    bytes_q.push_back(saida_dado);
                    ultimo_q.push_back(saida_ultimo);
                    ciclos_q.push_back(ciclo);
                    aceitou = 1;
                end
            end
            @(negedge clk);
            if (aceitou && aceitos == idx_esc_b && !esc_b) begin
                banco[reg_b] = val_b;
                esc_b        = 1;
            end
            ciclo++;
        end
        iniciar = 1'b0;
        if (!fim_visto) begin
            confere("timeout_concluido", 32'd0, 32'd1);
        end else begin
            confere("ocupado_apos_fim", ocupado, 1'b0);
            confere("concluido_pulso", concluido, 1'b0);
        end
        confere("ocupado_durante", ocupado_falhas, 0);
    endtask

    task automatic confere_dump(input string tag, input logic [31:0] esp);
        logic [7:0] cs;
        logic [7:0] e;
        cs = '0;
        confere($sformatf("%s_n_bytes", tag), bytes_q.size(), N_BYTES);
        for (int i = 0; i < 4; i++) begin
            e  = esp[31-8*i -: 8];
            cs = cs ^ e;
            if (i < bytes_q.size()) begin
                confere($sformatf("%s_byte%0d", tag, i), bytes_q[i], e);
                confere($sformatf("%s_ultimo%0d", tag, i), ultimo_q[i], (i == N_BYTES - 1));
            end
        end
`ifdef LEITOR_CHECKSUM_EN
        if (bytes_q.size() > 4) begin
            confere($sformatf("%s_checksum", tag), bytes_q[4], cs);
            confere($sformatf("%s_ultimo_cs", tag), ultimo_q[4], 1'b1);
        end
`endif
        confere($sformatf("%s_n_concluido", tag), n_concluido, 1);
        if (ciclos_q.size() > 0) begin
            confere($sformatf("%s_lat_concluido", tag), ciclo_conc - ciclos_q[ciclos_q.size()-1], 1);
        end
    endtask

    initial begin
        int  limite;
        bit  disparou;
        reset        = 1'b1;
        iniciar      = 1'b0;
        saida_pronta = 1'b0;
        carrega_banco(32'h11223344);
        #2;
        confere("rst_valida", saida_valida, 1'b0);
        confere("rst_ocupado", ocupado, 1'b0);
        confere("rst_concluido", concluido, 1'b0);
        confere("rst_ultimo", saida_ultimo, 1'b0);
        confere("rst_dado", saida_dado, 8'h00);
        confere("rst_end", endereco_leitura, 2'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        saida_pronta = 1'b1;
        @(negedge clk);
        confere("ocioso_pronta_sem_efeito", ocupado, 1'b0);

        // Free-flowing dump
        carrega_banco(32'h11223344);
        roda_dump(-1, 0, 8'h00, -1, 0, 8'h00, -1, 0, 8'h00, -1);
        confere_dump("basico", 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            if (i + 1 < ciclos_q.size())
                confere($sformatf("basico_intervalo%0d", i), ciclos_q[i+1] - ciclos_q[i], 2);
        end
`ifdef LEITOR_CHECKSUM_EN
        if (ciclos_q.size() > 4) confere("basico_intervalo_cs", ciclos_q[4] - ciclos_q[3], 1);
`endif

        // Consumer stalls five cycles on the second byte
        carrega_banco(32'h11223344);
        roda_dump(1, 5, 8'h22, -1, 0, 8'h00, -1, 0, 8'h00, -1);
        confere_dump("parada", 32'h11223344);

        // Bank writes before and after the affected register's read
        carrega_banco(32'h11223344);
        roda_dump(-1, 0, 8'h00, 0, 3, 8'hAA, 0, 0, 8'h55, -1);
        confere_dump("escrita", 32'h112233AA);

        // Spurious iniciar mid-dump is ignored
        carrega_banco(32'h11223344);
        roda_dump(-1, 0, 8'h00, -1, 0, 8'h00, -1, 0, 8'h00, 5);
        confere_dump("reinicio", 32'h11223344);

        // Asynchronous reset while the third byte is on offer
        carrega_banco(32'h11223344);
        saida_pronta = 1'b1;
        iniciar      = 1'b1;
        @(negedge clk);
        iniciar  = 1'b0;
        limite   = 0;
        disparou = 0;
        bytes_q.delete();
        while (limite < 100 && !disparou) begin
            if (saida_valida && bytes_q.size() == 2) begin
                disparou = 1;
            end else begin
                if (saida_valida) bytes_q.push_back(saida_dado);
                @(negedge clk);
                limite++;
            end
        end
        confere("reset_alcancou_byte2", disparou, 1'b1);
        confere("reset_byte2_dado", saida_dado, 8'h33);
        reset = 1'b1;
        #1;
        confere("reset_meio_valida", saida_valida, 1'b0);
        confere("reset_meio_ocupado", ocupado, 1'b0);
        confere("reset_meio_concluido", concluido, 1'b0);
        confere("reset_meio_ultimo", saida_ultimo, 1'b0);
        confere("reset_meio_dado", saida_dado, 8'h00);
        confere("reset_meio_end", endereco_leitura, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        n_concluido = 0;
        for (int i = 0; i < 4; i++) begin
            if (concluido) n_concluido++;
            @(negedge clk);
        end
        confere("reset_sem_concluido", n_concluido, 0);
        roda_dump(-1, 0, 8'h00, -1, 0, 8'h00, -1, 0, 8'h00, -1);
        confere_dump("pos_reset", 32'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
